// File: rtl/led_anim_sequencer.sv
// ---------------------------------------------------------------------------
// led_anim_sequencer
//
// Produces the step index for the 10-LED pattern decoder. Walks a segment
// [seg_lo..seg_hi] of the pattern table at a programmable rate in loop,
// one-shot or ping-pong mode, with start / stop / pause control pulses.
//
// Parameters
//   TICK_DIV  clock cycles per step at speed=0 (>= 8, multiple of 8)
//   STEP_W    width of the step index (table depth 2**STEP_W)
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous reset, active-high
//   start   in   pulse: latch mode/speed/segment, begin at seg_lo
//   stop    in   pulse: abort and return to IDLE
//   pause   in   pulse: toggle RUN <-> PAUSE
//   mode    in   00 loop, 01 one-shot, 10 ping-pong, 11 loop
//   speed   in   step period = TICK_DIV >> speed cycles
//   seg_lo  in   first step of segment
//   seg_hi  in   last step of segment
//   step    out  index to the pattern decoder
//   busy    out  high in RUN or PAUSE
//   dir     out  0 counting up, 1 counting down (ping-pong only)
//   done    out  pulse: one-shot segment finished
//   wrap    out  pulse: loop wrapped hi->lo, or ping-pong reversed
//   err     out  pulse: start rejected because seg_lo > seg_hi
// ---------------------------------------------------------------------------
module led_anim_sequencer #(
  parameter int TICK_DIV = 5_000_000,
  parameter int STEP_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [1:0]        speed,
  input  logic [STEP_W-1:0] seg_lo,
  input  logic [STEP_W-1:0] seg_hi,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              dir,
  output logic              done,
  output logic              wrap,
  output logic              err
);

  // Prescaler only has to hold 0..TICK_DIV-1.
  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  state_t            state_reg;
  logic [1:0]        mode_reg;
  logic [1:0]        speed_reg;
  logic [STEP_W-1:0] lo_reg;
  logic [STEP_W-1:0] hi_reg;
  logic [PW-1:0]     presc_reg;
  logic [PW-1:0]     period_last;

  // Terminal prescaler count (P-1) for the latched speed. TICK_DIV being a
  // multiple of 8 keeps P >= 1 even at speed=3.
  always_comb begin
    period_last = PW'((TICK_DIV >> speed_reg) - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      mode_reg  <= '0;
      speed_reg <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      presc_reg <= '0;
      step      <= '0;
      busy      <= 1'b0;
      dir       <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Status pulses are high for exactly one cycle.
      done <= 1'b0;
      wrap <= 1'b0;
      err  <= 1'b0;

      if (stop) begin
        state_reg <= IDLE;
        step      <= '0;
        dir       <= 1'b0;
        presc_reg <= '0;
        busy      <= 1'b0;
      end else if (start) begin
        if (seg_lo > seg_hi) begin
          err       <= 1'b1;
          state_reg <= IDLE;
          step      <= '0;
          dir       <= 1'b0;
          presc_reg <= '0;
          busy      <= 1'b0;
        end else begin
          mode_reg  <= mode;
          speed_reg <= speed;
          lo_reg    <= seg_lo;
          hi_reg    <= seg_hi;
          step      <= seg_lo;
          dir       <= 1'b0;
          presc_reg <= '0;
          state_reg <= RUN;
          busy      <= 1'b1;
        end
      end else begin
        case (state_reg)
          RUN: begin
            if (pause) begin
              // Prescaler and step freeze where they are.
              state_reg <= PAUSE;
            end else if (presc_reg == period_last) begin
              presc_reg <= '0;
              case (mode_reg)
                MODE_ONESHOT: begin
                  if (step < hi_reg) begin
                    step <= step + STEP_W'(1);
                  end else begin
                    done      <= 1'b1;
                    state_reg <= DONE;
                    busy      <= 1'b0;
                  end
                end
                MODE_PINGPONG: begin
                  // A one-entry segment has nowhere to bounce: hold quietly.
                  if (lo_reg != hi_reg) begin
                    if (!dir) begin
                      if (step < hi_reg) begin
                        step <= step + STEP_W'(1);
                      end else begin
                        dir  <= 1'b1;
                        step <= hi_reg - STEP_W'(1);
                        wrap <= 1'b1;
                      end
                    end else begin
                      if (step > lo_reg) begin
                        step <= step - STEP_W'(1);
                      end else begin
                        dir  <= 1'b0;
                        step <= lo_reg + STEP_W'(1);
                        wrap <= 1'b1;
                      end
                    end
                  end
                end
                default: begin
                  if (step < hi_reg) begin
                    step <= step + STEP_W'(1);
                  end else begin
                    step <= lo_reg;
                    wrap <= 1'b1;
                  end
                end
              endcase
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
          end
          PAUSE: begin
            // Resume from the frozen prescaler value.
            if (pause) begin
              state_reg <= RUN;
            end
          end
          default: begin
            // IDLE and DONE wait for start or stop; pause is ignored.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_anim_sequencer.sv
module tb_led_anim_sequencer;

  localparam int TICK_DIV = 8;
  localparam int STEP_W   = 7;

  logic              clk;
  logic              rst;
  logic              start;
  logic              stop;
  logic              pause;
  logic [1:0]        mode;
  logic [1:0]        speed;
  logic [STEP_W-1:0] seg_lo;
  logic [STEP_W-1:0] seg_hi;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              dir;
  logic              done;
  logic              wrap;
  logic              err;

  int checks = 0;
  int errors = 0;

  led_anim_sequencer #(
    .TICK_DIV(TICK_DIV),
    .STEP_W  (STEP_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .mode  (mode),
    .speed (speed),
    .seg_lo(seg_lo),
    .seg_hi(seg_hi),
    .step  (step),
    .busy  (busy),
    .dir   (dir),
    .done  (done),
    .wrap  (wrap),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance n clock edges, landing 1 time unit after the last one.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [1:0] s,
                          input logic [STEP_W-1:0] lo, input logic [STEP_W-1:0] hi);
    mode   = m;
    speed  = s;
    seg_lo = lo;
    seg_hi = hi;
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    pause  = 1'b0;
    mode   = 2'b00;
    speed  = 2'b00;
    seg_lo = '0;
    seg_hi = '0;

    // Reset state
    #12;
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_dir",  dir,  0);
    check("rst_pulses", {done, wrap, err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(3);
    check("idle_busy", busy, 0);

    // 1: loop 13..31, speed 0 (P=8)
    do_start(2'b00, 2'd0, 7'd13, 7'd31);
    seg_lo = 7'd0;          // config changes after start are ignored
    mode   = 2'b01;
    check("loop_first_step", step, 13);
    check("loop_busy", busy, 1);
    cyc(7);
    check("loop_before_tick", step, 13);
    cyc(1);
    check("loop_first_tick", step, 14);
    cyc(136);
    check("loop_at_hi", step, 31);
    check("loop_no_wrap_yet", wrap, 0);
    cyc(8);
    check("loop_wrapped_step", step, 13);
    check("loop_wrap_pulse", wrap, 1);
    check("loop_busy_wrap", busy, 1);
    cyc(1);
    check("loop_wrap_1cyc", wrap, 0);
    pulse_stop();
    check("stop_step", step, 0);
    check("stop_busy", busy, 0);

    // 2: one-shot 48..58, speed 3 (P=1)
    do_start(2'b01, 2'd3, 7'd48, 7'd58);
    check("os_first", step, 48);
    cyc(1);
    check("os_second", step, 49);
    cyc(9);
    check("os_at_hi", step, 58);
    check("os_busy_at_hi", busy, 1);
    check("os_no_done_yet", done, 0);
    cyc(1);
    check("os_done", done, 1);
    check("os_busy_done", busy, 0);
    check("os_step_held", step, 58);
    cyc(1);
    check("os_done_1cyc", done, 0);
    pulse_pause();            // ignored in DONE
    cyc(4);
    check("os_done_hold_step", step, 58);
    check("os_done_hold_busy", busy, 0);

    // 3: ping-pong 77..91, speed 2 (P=2)
    do_start(2'b10, 2'd2, 7'd77, 7'd91);
    check("pp_first", step, 77);
    check("pp_dir_up", dir, 0);
    cyc(28);
    check("pp_at_hi", step, 91);
    check("pp_at_hi_dir", dir, 0);
    cyc(2);
    check("pp_rev_step", step, 90);
    check("pp_rev_dir", dir, 1);
    check("pp_rev_wrap", wrap, 1);
    cyc(1);
    check("pp_rev_wrap_1cyc", wrap, 0);
    cyc(25);
    check("pp_at_lo", step, 77);
    check("pp_at_lo_dir", dir, 1);
    cyc(2);
    check("pp_rev2_step", step, 78);
    check("pp_rev2_dir", dir, 0);
    check("pp_rev2_wrap", wrap, 1);

    // 4: pause with prescaler at 3, speed 0 (P=8)
    do_start(2'b00, 2'd0, 7'd5, 7'd20);
    check("pz_dir_cleared", dir, 0);
    cyc(3);                   // prescaler now 3
    pulse_pause();
    check("pz_busy", busy, 1);
    cyc(20);
    check("pz_frozen", step, 5);
    pulse_pause();            // resume
    cyc(4);
    check("pz_resume_before", step, 5);
    cyc(1);
    check("pz_resume_tick", step, 6);
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    check("ss_step", step, 0);
    check("ss_busy", busy, 0);
    cyc(10);
    check("ss_idle_step", step, 0);

    // 5: rejected start
    do_start(2'b00, 2'd0, 7'd40, 7'd20);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_step", step, 0);
    cyc(1);
    check("err_1cyc", err, 0);

    // Single-entry segments
    do_start(2'b00, 2'd3, 7'd3, 7'd3);
    cyc(1);
    check("loop1_step", step, 3);
    check("loop1_wrap", wrap, 1);
    cyc(1);
    check("loop1_wrap_again", wrap, 1);
    do_start(2'b10, 2'd3, 7'd3, 7'd3);
    cyc(2);
    check("pp1_step", step, 3);
    check("pp1_wrap", wrap, 0);
    check("pp1_dir", dir, 0);
    do_start(2'b01, 2'd3, 7'd3, 7'd3);
    cyc(1);
    check("os1_done", done, 1);
    check("os1_busy", busy, 0);

    // 6: async reset mid-run
    do_start(2'b00, 2'd0, 7'd100, 7'd110);
    cyc(10);
    check("rr_running", step, 101);
    #2;
    rst = 1'b1;
    #1;
    check("rr_async_step", step, 0);
    check("rr_async_busy", busy, 0);
    #10;
    rst = 1'b0;
    cyc(20);
    check("rr_after_step", step, 0);
    check("rr_after_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
